// File: rtl/class_hvec_pkg.sv
// Shared types and default sizing for the class-hypervector store and streamer.
package class_hvec_pkg;

  localparam int DEF_FRAME_W     = 64;
  localparam int DEF_NUM_CLASSES = 8;
  localparam int DEF_NUM_FRAMES  = 3;
  localparam int DEF_CLASS_W     = $clog2(DEF_NUM_CLASSES);
  localparam int DEF_FRAME_IDX_W = $clog2(DEF_NUM_FRAMES);

  typedef enum logic {IDLE, STREAM} state_t;

  typedef logic [DEF_FRAME_W-1:0]     frame_t;
  typedef logic [DEF_CLASS_W-1:0]     class_idx_t;
  typedef logic [DEF_FRAME_IDX_W-1:0] frame_idx_t;

endpackage

// File: rtl/class_hvec_store.sv
// Class-hypervector register array: one synchronous write port, one
// combinational read port, cleared by reset.
module class_hvec_store
  import class_hvec_pkg::*;
#(
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int CLASS_W     = $clog2(NUM_CLASSES),
  parameter int FRAME_IDX_W = $clog2(NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [CLASS_W-1:0]     wr_class_i,
  input  logic [FRAME_IDX_W-1:0] wr_frame_i,
  input  logic [FRAME_W-1:0]     wr_data_i,
  input  logic [CLASS_W-1:0]     rd_class_i,
  input  logic [FRAME_IDX_W-1:0] rd_frame_i,
  output logic [FRAME_W-1:0]     rd_data_o
);

  logic [FRAME_W-1:0] mem_q [NUM_CLASSES][NUM_FRAMES];

  // Callers qualify wr_en_i with range checks, so indices here are in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          mem_q[c][f] <= '0;
        end
      end
    end else if (wr_en_i) begin
      mem_q[wr_class_i][wr_frame_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_class_i][rd_frame_i];

endmodule

// File: rtl/class_hvec_stream.sv
// Writable class-hypervector store that streams one class, or all classes in
// sweep mode, frame by frame over a valid/ready interface.
module class_hvec_stream
  import class_hvec_pkg::*;
#(
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int CLASS_W     = $clog2(NUM_CLASSES),
  parameter int FRAME_IDX_W = $clog2(NUM_FRAMES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CLASS_W-1:0]     req_class,
  input  logic                   req_sweep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_W-1:0]     out_data,
  output logic [CLASS_W-1:0]     out_class,
  output logic [FRAME_IDX_W-1:0] out_frame,
  output logic                   out_last,
  output logic                   out_sweep_last,
  input  logic                   wr_en,
  input  logic [CLASS_W-1:0]     wr_class,
  input  logic [FRAME_IDX_W-1:0] wr_frame,
  input  logic [FRAME_W-1:0]     wr_data,
  output logic                   err_oob
);

  localparam int LC_I = NUM_CLASSES - 1;
  localparam int LF_I = NUM_FRAMES - 1;
  localparam logic [CLASS_W-1:0]     LAST_CLASS = LC_I[CLASS_W-1:0];
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = LF_I[FRAME_IDX_W-1:0];
  localparam logic [CLASS_W:0]       CLASS_CNT  = NUM_CLASSES[CLASS_W:0];
  localparam logic [FRAME_IDX_W:0]   FRAME_CNT  = NUM_FRAMES[FRAME_IDX_W:0];

  state_t                 state_q, state_d;
  logic                   sweep_q, sweep_d;
  logic                   valid_q, valid_d;
  logic [CLASS_W-1:0]     class_q, class_d;
  logic [FRAME_IDX_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0]     data_q;
  logic                   last_q, last_d;
  logic                   slast_q, slast_d;
  logic                   err_q, err_d;
  logic                   load;
  logic                   req_in_range, wr_in_range, wr_ok;
  logic [FRAME_W-1:0]     rd_data;

  assign req_in_range = req_sweep || ({1'b0, req_class} < CLASS_CNT);
  assign wr_in_range  = ({1'b0, wr_class} < CLASS_CNT) && ({1'b0, wr_frame} < FRAME_CNT);
  assign wr_ok        = wr_en && wr_in_range;

  // The read port is addressed with the next counters, so the output register
  // captures the array contents before any same-edge write lands.
  class_hvec_store #(
    .FRAME_W    (FRAME_W),
    .NUM_CLASSES(NUM_CLASSES),
    .NUM_FRAMES (NUM_FRAMES),
    .CLASS_W    (CLASS_W),
    .FRAME_IDX_W(FRAME_IDX_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok),
    .wr_class_i(wr_class),
    .wr_frame_i(wr_frame),
    .wr_data_i (wr_data),
    .rd_class_i(class_d),
    .rd_frame_i(frame_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    valid_d = valid_q;
    class_d = class_q;
    frame_d = frame_q;
    load    = 1'b0;
    err_d   = wr_en && !wr_in_range;
    if (state_q == IDLE) begin
      if (req_valid && req_in_range) begin
        state_d = STREAM;
        sweep_d = req_sweep;
        valid_d = 1'b1;
        class_d = req_sweep ? '0 : req_class;
        frame_d = '0;
        load    = 1'b1;
      end else if (req_valid) begin
        err_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      if (frame_q != LAST_FRAME) begin
        frame_d = frame_q + 1'b1;
        load    = 1'b1;
      end else if (sweep_q && (class_q != LAST_CLASS)) begin
        class_d = class_q + 1'b1;
        frame_d = '0;
        load    = 1'b1;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end
    last_d  = (frame_d == LAST_FRAME);
    slast_d = last_d && (!sweep_d || (class_d == LAST_CLASS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sweep_q <= 1'b0;
      valid_q <= 1'b0;
      class_q <= '0;
      frame_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      slast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (load) begin
        class_q <= class_d;
        frame_q <= frame_d;
        data_q  <= rd_data;
        last_q  <= last_d;
        slast_q <= slast_d;
      end
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_class      = class_q;
  assign out_frame      = frame_q;
  assign out_last       = last_q;
  assign out_sweep_last = slast_q;
  assign err_oob        = err_q;

endmodule

// File: tb/tb_class_hvec_stream.sv
// Directed bench for class_hvec_stream with a frame scoreboard and a second
// six-class instance for out-of-range requests.
module tb_class_hvec_stream;
  import class_hvec_pkg::*;

  typedef struct packed {
    frame_t     data;
    class_idx_t cls;
    frame_idx_t frm;
    logic       last;
    logic       slast;
  } exp_t;

  logic clk, rst_n;
  logic req_valid, req_ready, req_sweep, out_valid, out_ready;
  logic out_last, out_sweep_last, wr_en, err_oob;
  class_idx_t req_class, out_class, wr_class;
  frame_idx_t out_frame, wr_frame;
  frame_t     out_data, wr_data;

  logic req_valid6, req_ready6, out_valid6, out_ready6, out_last6, out_slast6;
  logic wr_en6, err_oob6;
  logic [2:0] req_class6, out_class6, wr_class6;
  logic [1:0] out_frame6, wr_frame6;
  logic [63:0] out_data6;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  frame_t mem [8][3];

  class_hvec_stream u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_sweep(req_sweep), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .out_frame(out_frame), .out_last(out_last), .out_sweep_last(out_sweep_last),
    .wr_en(wr_en), .wr_class(wr_class), .wr_frame(wr_frame), .wr_data(wr_data),
    .err_oob(err_oob)
  );

  class_hvec_stream #(.NUM_CLASSES(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid6), .req_ready(req_ready6),
    .req_class(req_class6), .req_sweep(1'b0), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_data(out_data6), .out_class(out_class6),
    .out_frame(out_frame6), .out_last(out_last6), .out_sweep_last(out_slast6),
    .wr_en(wr_en6), .wr_class(wr_class6), .wr_frame(wr_frame6), .wr_data(64'h55),
    .err_oob(err_oob6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t pat(input int c, input int f);
    return {32'(c), 32'(f)} ^ 64'hDEAD_0000_BEEF_0000;
  endfunction

  task automatic push_xfer(input logic sw, input int cls);
    exp_t e;
    int c0, c1;
    c0 = sw ? 0 : cls;
    c1 = sw ? 7 : cls;
    for (int c = c0; c <= c1; c++) begin
      for (int f = 0; f < 3; f++) begin
        e.data  = mem[c][f];
        e.cls   = 3'(c);
        e.frm   = 2'(f);
        e.last  = (f == 2);
        e.slast = (f == 2) && (!sw || c == 7);
        q.push_back(e);
      end
    end
  endtask

  task automatic wr(input int c, input int f, input frame_t d);
    wr_en = 1'b1; wr_class = 3'(c); wr_frame = 2'(f); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (c < 8 && f < 3) mem[c][f] = d;
  endtask

  task automatic req(input logic sw, input int c);
    req_valid = 1'b1; req_sweep = sw; req_class = 3'(c);
    push_xfer(sw, c);
    tick();
    req_valid = 1'b0; req_sweep = 1'b0;
  endtask

  task automatic drain(input string tag, input logic rnd);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else     out_ready = 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    chk({tag, "_idle"}, 64'(req_ready), 64'd1);
  endtask

  // Scoreboard: the frame on the bus must always equal the queue head; it is
  // retired when a handshake will occur at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_frame", 64'(out_valid), 64'd0);
      end else begin
        chk("sb_data",  out_data, q[0].data);
        chk("sb_class", 64'(out_class), 64'(q[0].cls));
        chk("sb_frame", 64'(out_frame), 64'(q[0].frm));
        chk("sb_last",  64'(out_last), 64'(q[0].last));
        chk("sb_slast", 64'(out_sweep_last), 64'(q[0].slast));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 0; req_sweep = 0; req_class = '0; out_ready = 1'b1;
    wr_en = 0; wr_class = '0; wr_frame = '0; wr_data = '0;
    req_valid6 = 0; req_class6 = '0; out_ready6 = 1'b1;
    wr_en6 = 0; wr_class6 = '0; wr_frame6 = '0;
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) mem[c][f] = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_class", 64'(out_class), 64'd0);
    chk("rst_frame", 64'(out_frame), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_slast", 64'(out_sweep_last), 64'd0);
    chk("rst_err", 64'(err_oob), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single class 2, full rate
    wr(2, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    wr(2, 1, 64'hBBBB_BBBB_BBBB_BBBB);
    wr(2, 2, 64'hCCCC_CCCC_CCCC_CCCC);
    req(1'b0, 2);
    chk("c2_ready_busy", 64'(req_ready), 64'd0);
    chk("c2_valid", 64'(out_valid), 64'd1);
    chk("c2_frame0", 64'(out_frame), 64'd0);
    tick(); tick();
    chk("c2_lastC", 64'(out_last), 64'd1);
    chk("c2_dataC", out_data, 64'hCCCC_CCCC_CCCC_CCCC);
    tick();
    chk("c2_ready_back", 64'(req_ready), 64'd1);
    chk("c2_valid_off", 64'(out_valid), 64'd0);
    chk("c2_q_empty", 64'(q.size()), 64'd0);

    // Full sweep, no stalls
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) wr(c, f, pat(c, f));
    req(1'b1, 5);
    for (int i = 0; i < 24; i++) begin
      chk("sweep_nobubble", 64'(out_valid), 64'd1);
      tick();
    end
    chk("sweep_end_valid", 64'(out_valid), 64'd0);
    chk("sweep_end_ready", 64'(req_ready), 64'd1);
    chk("sweep_q_empty", 64'(q.size()), 64'd0);

    // Sweep under random backpressure
    out_ready = 1'b0;
    req(1'b1, 0);
    drain("stall_sweep", 1'b1);

    // Same-edge write and read of class 3 frame 1
    wr(3, 1, 64'h1234_5678_9ABC_DEF0);
    req(1'b0, 3);
    wr(3, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("coll_old", out_data, 64'h1234_5678_9ABC_DEF0);
    drain("coll", 1'b0);
    req(1'b0, 3);
    tick();
    chk("coll_new", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("coll2", 1'b0);

    // A held frame is not altered by a later write
    out_ready = 1'b0;
    req(1'b0, 4);
    wr(4, 0, 64'h0BAD_0BAD_0BAD_0BAD);
    chk("held_frame", out_data, pat(4, 0));
    drain("held", 1'b0);

    // Rejected write on the default instance
    wr(0, 3, 64'h9999);
    chk("wr_oob_pulse", 64'(err_oob), 64'd1);
    tick();
    chk("wr_oob_clear", 64'(err_oob), 64'd0);
    req(1'b0, 0);
    drain("wr_oob_store", 1'b0);

    // Six-class instance: out-of-range request and write in one cycle
    req_valid6 = 1'b1; req_class6 = 3'd7;
    wr_en6 = 1'b1; wr_class6 = 3'd6; wr_frame6 = 2'd0;
    tick();
    req_valid6 = 1'b0; wr_en6 = 1'b0;
    chk("c6_err", 64'(err_oob6), 64'd1);
    chk("c6_valid", 64'(out_valid6), 64'd0);
    chk("c6_ready", 64'(req_ready6), 64'd1);
    tick();
    chk("c6_err_single", 64'(err_oob6), 64'd0);
    chk("c6_valid2", 64'(out_valid6), 64'd0);
    wr_en6 = 1'b1; wr_class6 = 3'd1; wr_frame6 = 2'd3;
    tick();
    wr_en6 = 1'b0;
    chk("c6_wr_frame_err", 64'(err_oob6), 64'd1);
    req_valid6 = 1'b1; req_class6 = 3'd1;
    tick();
    req_valid6 = 1'b0;
    chk("c6_store_valid", 64'(out_valid6), 64'd1);
    chk("c6_store_data", out_data6, 64'd0);
    repeat (3) tick();
    chk("c6_done", 64'(out_valid6), 64'd0);

    // Reset in the middle of a sweep
    req(1'b1, 0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    q.delete();
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) mem[c][f] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    req(1'b0, 5);
    chk("post_rst_zero", out_data, 64'd0);
    drain("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/class_hvec_stream.md
Name: class_hvec_stream

Overview:
- Parametrised, writable successor to the fixed class-hypervector lookup.
- Holds NUM_CLASSES class hypervectors, each split into NUM_FRAMES frames of FRAME_W bits, in a register array that training logic loads at run time.
- Streams one class, or all classes in sweep mode, frame by frame over a valid/ready interface to the associative-search datapath.

Parameters:
- FRAME_W, 64, bits per frame (DI_PARALLEL_W_BITS of the datapath).
- NUM_CLASSES, 8, number of class vectors; must be ≥2.
- NUM_FRAMES, 3, frames per class vector; must be ≥2.
- CLASS_W, $clog2(NUM_CLASSES), class index width.
- FRAME_IDX_W, $clog2(NUM_FRAMES), frame index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  1  stream request.
- req_ready  out  1  block idle and able to accept a request.
- req_class  in  CLASS_W  class to stream; ignored when req_sweep=1.
- req_sweep  in  1  1 = stream all classes, 0 .. NUM_CLASSES-1.
- out_valid  out  1  out_data holds a frame.
- out_ready  in  1  consumer accepts the frame.
- out_data  out  FRAME_W  frame contents.
- out_class  out  CLASS_W  class of the current frame.
- out_frame  out  FRAME_IDX_W  index of the current frame.
- out_last  out  1  last frame of the current class.
- out_sweep_last  out  1  last frame of the whole transfer.
- wr_en  in  1  write one frame into the store.
- wr_class  in  CLASS_W  target class.
- wr_frame  in  FRAME_IDX_W  target frame.
- wr_data  in  FRAME_W  frame data.
- err_oob  out  1  one-cycle pulse: out-of-range request or write was rejected.

Behaviour:
- Reset: store cleared to all zeros; state IDLE; req_ready=1; out_valid=0; out_data/out_class/out_frame=0; out_last=0; out_sweep_last=0; err_oob=0.
- A reset asserted mid-stream aborts the transfer immediately. No partial frame is held.
- States:
  - IDLE: req_ready=1.
  - STREAM: req_ready=0.
- Request acceptance: req_valid && req_ready.
  - Class counter = 0 if sweep, else req_class. Frame counter = 0.
  - The output register loads frame 0 on the same edge, so out_valid=1 on the next cycle (latency 1).
- Out-of-range request (non-sweep, req_class ≥ NUM_CLASSES): not accepted into STREAM. err_oob pulses for 1 cycle, state stays IDLE.
- Advance on out_valid && out_ready:
  - Frame < NUM_FRAMES-1: frame+1.
  - Else, if sweep and class < NUM_CLASSES-1: class+1, frame=0.
  - Else: out_valid=0 next cycle, return to IDLE (req_ready=1 that cycle).
  - The output register reloads on the same edge, giving one frame per cycle with no bubbles while out_ready=1.
- Backpressure: while out_valid && !out_ready, all out_* signals are held stable. Counters do not move.
- out_last = (out_frame == NUM_FRAMES-1).
- out_sweep_last = out_last && (non-sweep transfer, or out_class == NUM_CLASSES-1).
- Writes are accepted in any state, applied at the edge, and visible to reads from the next cycle.
- Write/read collision: if the output register loads the same class/frame in the same cycle, it captures the OLD contents (read-before-write). The write still lands.
- A frame already sitting in the output register is never altered by a later write.
- Write with wr_class ≥ NUM_CLASSES or wr_frame ≥ NUM_FRAMES: ignored, err_oob pulses.
- If a rejected request and a rejected write occur in the same cycle, err_oob is a single 1-cycle pulse.
- No arithmetic beyond counter increments. Counters never wrap past their limits.

Decomposition:
- Package class_hvec_pkg holds:
  - typedef enum {IDLE, STREAM} state_t.
  - Frame and index typedefs derived from the parameters.
  - Default parameter constants.
- One sub-module, class_hvec_store: register array, one synchronous write port, one combinational read port, clear on rst_n.
- FSM, counters and output register live in the top.

Test Plan:
- Reset, then write class 2 frames 0..2 = 64'hA..., 64'hB..., 64'hC...; request class 2 with out_ready=1 → 3 consecutive frames A, B, C with out_frame 0,1,2; out_last only on C; req_ready back to 1 the cycle after C.
- Sweep with class c frame f written as {c,f} patterns, out_ready=1 → 24 frames in class-major order; out_last every 3rd frame; out_sweep_last only on class 7 frame 2; no bubbles.
- Toggle out_ready randomly during a sweep → data and indices held stable while stalled; the sequence matches the no-stall run exactly.
- Write class 3 frame 1 = 64'hFFFF... in the same cycle the output register loads class 3 frame 1 (old value 64'h1234...) → out_data = 64'h1234...; a later request returns 64'hFFFF....
- With NUM_CLASSES=6, request class 7 → err_oob for 1 cycle, out_valid stays 0. A write to frame 3 → err_oob, store unchanged.
- Assert rst_n low mid-sweep → out_valid=0 and req_ready=1 immediately (asynchronously); a subsequent request of any class returns zeros.
